// File: rtl/flag_bank_if.sv
// Requester-side bus of the shared flag bank: per-requester valid/op/index in,
// one-hot ready plus bank status out.
interface flag_bank_if #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned NUM_FLAGS = 8,
  parameter int unsigned IDX_W     = (NUM_FLAGS > 1) ? $clog2(NUM_FLAGS) : 1
);
  localparam int unsigned GID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [2*NUM_REQ-1:0]     req_op;
  logic [IDX_W*NUM_REQ-1:0] req_idx;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_FLAGS-1:0]     flags;
  logic                     busy;
  logic [GID_W-1:0]         grant_id;
  logic                     err;

  modport master (
    output req_valid, req_op, req_idx,
    input  req_ready, flags, busy, grant_id, err
  );

  modport slave (
    input  req_valid, req_op, req_idx,
    output req_ready, flags, busy, grant_id, err
  );
endinterface

// File: rtl/flag_bank_arbiter.sv
// Shared flag bank with a round-robin arbiter applying one set/clear/toggle per grant.
// Define FLAG_BANK_FIXED_PRIO_EN for fixed priority (lowest requester index wins).
module flag_bank_arbiter #(
  parameter int unsigned          NUM_REQ   = 4,
  parameter int unsigned          NUM_FLAGS = 8,
  parameter int unsigned          IDX_W     = (NUM_FLAGS > 1) ? $clog2(NUM_FLAGS) : 1,
  parameter logic [NUM_FLAGS-1:0] RESET_VAL = '0,
  parameter int unsigned          CLK_HZ    = 12_000_000
) (
  input  logic        clk,
  input  logic        rst,
  flag_bank_if.slave  bus
);

  localparam int unsigned GID_W = $clog2(NUM_REQ);

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  // Reject parameter sets the bank was never meant to support.
  if (NUM_REQ < 2 || NUM_REQ > 8 || NUM_FLAGS == 0 || NUM_FLAGS > 32 ||
      IDX_W < $clog2(NUM_FLAGS) || CLK_HZ == 0) begin : g_bad_cfg
    $error("flag_bank_arbiter: unsupported parameter set");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } state_t;

  state_t               state;
  logic [1:0]           lat_op;
  logic [IDX_W-1:0]     lat_idx;
  logic [GID_W-1:0]     grant_id;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_FLAGS-1:0] flags;
  logic                 busy;
  logic                 err;

  logic                 win_found;
  logic [GID_W-1:0]     win_id;
  logic [GID_W-1:0]     cand;
  logic [1:0]           win_op;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_oob;
  logic [NUM_FLAGS-1:0] lat_mask;

  // Winner search: first valid requester after the last grant, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
`ifdef FLAG_BANK_FIXED_PRIO_EN
      cand = GID_W'(k);
`else
      cand = GID_W'((32'(grant_id) + 32'(k) + 32'd1) % NUM_REQ);
`endif
      if (!win_found && bus.req_valid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  // Pick the winner's op and index out of the packed request buses.
  always_comb begin
    win_op  = OP_NOP;
    win_idx = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if (win_id == GID_W'(r)) begin
        win_op  = bus.req_op[2*r +: 2];
        win_idx = bus.req_idx[IDX_W*r +: IDX_W];
      end
    end
  end

  assign win_oob  = (32'(win_idx) >= NUM_FLAGS);
  assign lat_mask = NUM_FLAGS'(1) << lat_idx;

  // err doubles as the out-of-range marker for the latched op during APPLY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lat_op    <= OP_NOP;
      lat_idx   <= '0;
      grant_id  <= GID_W'(NUM_REQ - 1);
      req_ready <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
      flags     <= RESET_VAL;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            lat_op    <= win_op;
            lat_idx   <= win_idx;
            grant_id  <= win_id;
            req_ready <= NUM_REQ'(1) << win_id;
            busy      <= 1'b1;
            err       <= win_oob;
            state     <= APPLY;
          end
        end
        APPLY: begin
          if (!err) begin
            case (lat_op)
              OP_NOP:    ;
              OP_SET:    flags <= flags | lat_mask;
              OP_CLEAR:  flags <= flags & ~lat_mask;
              OP_TOGGLE: flags <= flags ^ lat_mask;
            endcase
          end
          req_ready <= '0;
          busy      <= 1'b0;
          err       <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.flags     = flags;
  assign bus.busy      = busy;
  assign bus.grant_id  = grant_id;
  assign bus.err       = err;

endmodule

// File: tb/tb_flag_bank_arbiter.sv
// Bench for flag_bank_arbiter: an 8-flag and a 6-flag bank share one set of
// requesters; directed table, hand sequences, then random traffic vs a model.
module tb_flag_bank_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned IW = 3;

  localparam logic [1:0] NOP = 2'b00;
  localparam logic [1:0] SET = 2'b01;
  localparam logic [1:0] CLR = 2'b10;
  localparam logic [1:0] TGL = 2'b11;

  logic               clk;
  logic               rst;
  logic [NR-1:0]      valid;
  logic [2*NR-1:0]    op;
  logic [IW*NR-1:0]   idx;

  int vectors;
  int miscompares;

  flag_bank_if #(.NUM_REQ(4), .NUM_FLAGS(8), .IDX_W(3)) bus8 ();
  flag_bank_if #(.NUM_REQ(4), .NUM_FLAGS(6), .IDX_W(3)) bus6 ();

  assign bus8.req_valid = valid;
  assign bus8.req_op    = op;
  assign bus8.req_idx   = idx;
  assign bus6.req_valid = valid;
  assign bus6.req_op    = op;
  assign bus6.req_idx   = idx;

  flag_bank_arbiter #(
    .NUM_REQ(4), .NUM_FLAGS(8), .IDX_W(3), .RESET_VAL(8'hA5), .CLK_HZ(12_000_000)
  ) dut8 (
    .clk(clk), .rst(rst), .bus(bus8)
  );

  flag_bank_arbiter #(
    .NUM_REQ(4), .NUM_FLAGS(6), .IDX_W(3), .RESET_VAL(6'h25), .CLK_HZ(12_000_000)
  ) dut6 (
    .clk(clk), .rst(rst), .bus(bus6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    valid = '0;
    op    = '0;
    idx   = '0;
  endtask

  task automatic set_req(input int r, input logic [1:0] o, input logic [2:0] i);
    valid[r]       = 1'b1;
    op[2*r +: 2]   = o;
    idx[3*r +: 3]  = i;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Single op from IDLE with no checks, used to prepare a known bank state.
  task automatic quiet_op(input int r, input logic [1:0] o, input logic [2:0] i);
    set_req(r, o, i);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
  endtask

  // Transaction-level reference: winner, latched op, and the two flag banks.
  logic [7:0] m_f8;
  logic [5:0] m_f6;
  int         m_last;
  bit         m_apply;
  int         m_op;
  int         m_idx;

  function automatic int pick(input logic [NR-1:0] v);
    for (int k = 0; k < int'(NR); k++) begin
      int c;
`ifdef FLAG_BANK_FIXED_PRIO_EN
      c = k;
`else
      c = (m_last + 1 + k) % int'(NR);
`endif
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [31:0] apply_op(input logic [31:0] f, input int n,
                                           input int o, input int i);
    logic [31:0] r;
    r = f;
    if (i < n) begin
      case (o)
        1: r[i] = 1'b1;
        2: r[i] = 1'b0;
        3: r[i] = ~r[i];
        default: ;
      endcase
    end
    return r;
  endfunction

  task automatic model_step();
    int w;
    if (m_apply) begin
      m_f8    = 8'(apply_op(32'(m_f8), 8, m_op, m_idx));
      m_f6    = 6'(apply_op(32'(m_f6), 6, m_op, m_idx));
      m_apply = 1'b0;
    end else begin
      w = pick(valid);
      if (w >= 0) begin
        m_last  = w;
        m_op    = int'(op[2*w +: 2]);
        m_idx   = int'(idx[3*w +: 3]);
        m_apply = 1'b1;
      end
    end
  endtask

  typedef struct {
    int         r;
    logic [1:0] o;
    logic [2:0] i;
    logic [7:0] f8;
    logic [5:0] f6;
    logic       e6;
  } vec_t;

  vec_t       tbl[8];
  int         exp_g[5];
  logic [7:0] exp_f[5];
  logic [7:0] prev8;
  logic [5:0] prev6;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    idle_inputs();

    // Cumulative ops starting from the reset banks 8'hA5 / 6'h25.
    tbl[0] = '{2, CLR, 3'd0, 8'hA4, 6'h24, 1'b0};
    tbl[1] = '{1, SET, 3'd6, 8'hE4, 6'h24, 1'b1};
    tbl[2] = '{3, TGL, 3'd1, 8'hE6, 6'h26, 1'b0};
    tbl[3] = '{0, NOP, 3'd5, 8'hE6, 6'h26, 1'b0};
    tbl[4] = '{1, TGL, 3'd7, 8'h66, 6'h26, 1'b1};
    tbl[5] = '{0, CLR, 3'd2, 8'h62, 6'h22, 1'b0};
    tbl[6] = '{3, SET, 3'd3, 8'h6A, 6'h2A, 1'b0};
    tbl[7] = '{2, SET, 3'd5, 8'h6A, 6'h2A, 1'b0};

    // Reset state, sampled while rst is still high.
    @(negedge clk);
    chk("rst_flags8",   32'(bus8.flags),     32'h A5);
    chk("rst_flags6",   32'(bus6.flags),     32'h 25);
    chk("rst_ready",    32'(bus8.req_ready), 32'h0);
    chk("rst_busy",     32'(bus8.busy),      32'h0);
    chk("rst_grant_id", 32'(bus8.grant_id),  32'd3);
    chk("rst_err",      32'(bus6.err),       32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    prev8 = 8'hA5;
    prev6 = 6'h25;
    foreach (tbl[n]) begin
      set_req(tbl[n].r, tbl[n].o, tbl[n].i);
      @(negedge clk);
      chk("tbl_ready",     32'(bus8.req_ready), 32'(1) << tbl[n].r);
      chk("tbl_busy",      32'(bus8.busy),      32'h1);
      chk("tbl_grant_id",  32'(bus8.grant_id),  32'(tbl[n].r));
      chk("tbl_err6",      32'(bus6.err),       32'(tbl[n].e6));
      chk("tbl_err8",      32'(bus8.err),       32'h0);
      chk("tbl_hold8",     32'(bus8.flags),     32'(prev8));
      idle_inputs();
      @(negedge clk);
      chk("tbl_flags8",    32'(bus8.flags),     32'(tbl[n].f8));
      chk("tbl_flags6",    32'(bus6.flags),     32'(tbl[n].f6));
      chk("tbl_ready_off", 32'(bus8.req_ready), 32'h0);
      chk("tbl_busy_off",  32'(bus8.busy),      32'h0);
      chk("tbl_err_off",   32'(bus6.err),       32'h0);
      prev8 = tbl[n].f8;
      prev6 = tbl[n].f6;
    end

    // Reset while an op is in APPLY: op discarded, bank back to reset value.
    set_req(0, TGL, 3'd0);
    @(negedge clk);
    chk("mid_apply_ready", 32'(bus8.req_ready), 32'h1);
    rst = 1'b1;
    idle_inputs();
    #1;
    chk("mid_rst_flags8",  32'(bus8.flags),     32'h A5);
    chk("mid_rst_ready",   32'(bus8.req_ready), 32'h0);
    chk("mid_rst_busy",    32'(bus8.busy),      32'h0);
    chk("mid_rst_gid",     32'(bus8.grant_id),  32'd3);
    @(negedge clk);
    chk("mid_rst_hold8",   32'(bus8.flags),     32'h A5);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_flags8", 32'(bus8.flags),     32'h A5);
    chk("post_rst_flags6", 32'(bus6.flags),     32'h 25);
    chk("post_rst_ready",  32'(bus8.req_ready), 32'h0);
    chk("post_rst_busy",   32'(bus8.busy),      32'h0);
    chk("post_rst_gid",    32'(bus8.grant_id),  32'd3);

    // Single set on an all-zero bank: ready one cycle after, flag one later.
    quiet_op(0, CLR, 3'd0);
    quiet_op(1, CLR, 3'd2);
    quiet_op(2, CLR, 3'd5);
    quiet_op(3, CLR, 3'd7);
    chk("zero_flags8", 32'(bus8.flags), 32'h0);
    set_req(2, SET, 3'd3);
    @(negedge clk);
    chk("single_ready",  32'(bus8.req_ready), 32'h4);
    chk("single_hold8",  32'(bus8.flags),     32'h0);
    idle_inputs();
    @(negedge clk);
    chk("single_flags8", 32'(bus8.flags),     32'h08);
    chk("single_flags6", 32'(bus6.flags),     32'h08);

    // All four requesters hold toggle on distinct flags.
    do_reset();
`ifdef FLAG_BANK_FIXED_PRIO_EN
    exp_g = '{0, 0, 0, 0, 0};
    exp_f = '{8'hA4, 8'hA5, 8'hA4, 8'hA5, 8'hA4};
`else
    exp_g = '{0, 1, 2, 3, 0};
    exp_f = '{8'hA4, 8'hA6, 8'hA2, 8'hAA, 8'hAB};
`endif
    for (int r = 0; r < int'(NR); r++) set_req(r, TGL, 3'(r));
    for (int g = 0; g < 5; g++) begin
      @(negedge clk);
      chk("rr_ready",  32'(bus8.req_ready), 32'(1) << exp_g[g]);
      chk("rr_gid",    32'(bus8.grant_id),  32'(exp_g[g]));
      @(negedge clk);
      chk("rr_flags8", 32'(bus8.flags),     32'(exp_f[g]));
    end
    idle_inputs();
    @(negedge clk);

    // Simultaneous set and clear of one flag: set first, then clear.
    do_reset();
    set_req(0, SET, 3'd5);
    set_req(1, CLR, 3'd5);
    @(negedge clk);
    chk("order_ready0", 32'(bus8.req_ready), 32'h1);
    valid[0] = 1'b0;
    @(negedge clk);
    chk("order_mid8",   32'(bus8.flags),     32'h A5);
    @(negedge clk);
    chk("order_ready1", 32'(bus8.req_ready), 32'h2);
    valid[1] = 1'b0;
    @(negedge clk);
    chk("order_final8", 32'(bus8.flags),     32'h85);
    chk("order_final6", 32'(bus6.flags),     32'h05);

    // Index changed while waiting and again during APPLY: grant-edge value wins.
    do_reset();
    set_req(0, NOP, 3'd0);
    set_req(1, SET, 3'd1);
    @(negedge clk);
    chk("stab_ready0", 32'(bus8.req_ready), 32'h1);
    valid[0]  = 1'b0;
    idx[3 +: 3] = 3'd4;
    @(negedge clk);
    @(negedge clk);
    chk("stab_ready1", 32'(bus8.req_ready), 32'h2);
    set_req(1, CLR, 3'd6);
    @(negedge clk);
    chk("stab_flags8", 32'(bus8.flags),     32'h B5);
    chk("stab_flags6", 32'(bus6.flags),     32'h 35);
    idle_inputs();

    // Random traffic against the reference model.
    do_reset();
    m_f8    = 8'hA5;
    m_f6    = 6'h25;
    m_last  = int'(NR) - 1;
    m_apply = 1'b0;
    m_op    = 0;
    m_idx   = 0;
    for (int c = 0; c < 600; c++) begin
      valid = 4'($urandom);
      if ($urandom_range(0, 3) == 0) valid = '0;
      op  = 8'($urandom);
      idx = 12'($urandom);
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("rnd_ready8", 32'(bus8.req_ready), m_apply ? (32'(1) << m_last) : 32'h0);
      chk("rnd_ready6", 32'(bus6.req_ready), m_apply ? (32'(1) << m_last) : 32'h0);
      chk("rnd_busy",   32'(bus8.busy),      32'(m_apply));
      chk("rnd_gid",    32'(bus8.grant_id),  32'(m_last));
      chk("rnd_err6",   32'(bus6.err),       32'(m_apply && m_idx >= 6));
      chk("rnd_err8",   32'(bus8.err),       32'h0);
      chk("rnd_flags8", 32'(bus8.flags),     32'(m_f8));
      chk("rnd_flags6", 32'(bus6.flags),     32'(m_f6));
    end
    idle_inputs();
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
